neo_dot_lbwriter: RTL and testbench
===================================

Name: neo_dot_lbwriter

Overview:
- Receiving end of the graphics-mux dot interface.
- Consumes the two 4-bit pixel streams (GAD/GBD) and their opacity flags (DOTA/DOTB) that the mux shifts out after each LOAD.
- Merges them with the sprite palette and X position latched at LOAD, and drives registered write strobes into the sprite line buffer.
- Transparent and off-screen pixels are never written.

Parameters:
- VIS_W, 320, visible line width; pixel addresses >= VIS_W are suppressed.
- BURST, 4, pixel-pair cycles per LOAD (8 pixels per 32-bit CR word).

Ports:
- CLK_12M  in  1  system clock; all state is sampled on the rising edge.
- nRESET  in  1  asynchronous active-low reset.
- LOAD  in  1  one-cycle strobe; a new CR word enters the mux this cycle.
- PAL  in  8  sprite palette number, sampled when LOAD=1.
- XPOS  in  9  sprite X start address, sampled when LOAD=1.
- GAD  in  4  pixel A colour index.
- GBD  in  4  pixel B colour index.
- DOTA  in  1  pixel A opaque (GAD != 0).
- DOTB  in  1  pixel B opaque.
- WE_A  out  1  line-buffer write strobe, pixel A.
- WE_B  out  1  line-buffer write strobe, pixel B.
- ADDR_A  out  9  write address, pixel A.
- ADDR_B  out  9  write address, pixel B.
- DATA_A  out  12  {PAL, GAD}.
- DATA_B  out  12  {PAL, GBD}.
- BUSY  out  1  burst in progress.
- DONE  out  1  one-cycle pulse on the final write cycle of a burst.

Behaviour:
- Reset (nRESET=0, async): every output is 0. Internal state is cleared: cnt=0, pal_r=0, x_r=0, state IDLE.
- States:
  - IDLE: BUSY=0. LOAD=1 -> latch PAL into pal_r and XPOS into x_r, cnt=0, go to RUN.
  - RUN: BUSY=1. Each cycle, consume one pixel pair:
    - A is at address x_r+2*cnt, B at x_r+2*cnt+1.
    - Addition is mod 512 (9-bit wrap, no carry out).
    - cnt increments each cycle.
    - After BURST pairs are consumed, return to IDLE unless LOAD is asserted.
- Pipeline: pair consumed in cycle n -> WE/ADDR/DATA registered and valid in cycle n+1. Fixed latency of 1.
  - For LOAD at cycle t: pairs are consumed in t+1..t+BURST and writes appear in t+2..t+BURST+1.
  - DONE is asserted together with the last pair's write outputs.
- Write gating, per pixel: WE_x = BUSY_pair & DOTx & (addr_x < VIS_W). ADDR and DATA are still updated when WE=0.
- Simultaneous LOAD during RUN: the current burst is truncated.
  - The pair consumed in the LOAD cycle still belongs to the old burst.
  - Attributes are relatched, cnt=0, state stays RUN.
  - No DONE is issued for the truncated burst.
- LOAD exactly in the final pair cycle: back-to-back bursts with no idle gap. DONE fires for the finished burst and BUSY stays 1.
- Wrap: XPOS=511 -> A@511, B@0, next pair A@1, B@2. Addresses >= VIS_W are suppressed; wrapped low addresses that are < VIS_W are written.
- Outputs in IDLE: WE_A=WE_B=0. ADDR and DATA hold their last value.
- Reset asserted mid-burst: outputs clear immediately (async). After release, the block is in IDLE and waits for the next LOAD. No partial resume.

Test Plan:
- Basic burst: LOAD, PAL=0x12, XPOS=8, GAD=1..4, GBD=5..8, all opaque -> WE_A/WE_B high for 4 cycles starting 2 cycles after LOAD; ADDR_A=8,10,12,14; ADDR_B=9,11,13,15; DATA_A=0x121..0x124; DONE on the 4th write cycle.
- Transparency: same stimulus with DOTB=0 on pairs 1 and 3 -> WE_B low exactly on the 1st and 3rd write cycles; WE_A unaffected.
- Clip and wrap: XPOS=316 -> writes only at 316..319 (pairs 1–2), pairs 3–4 suppressed. XPOS=510 -> addresses 510,511 suppressed; 0..5 written.
- Back-to-back: second LOAD in the final pair cycle with XPOS=100 -> 8 consecutive write cycles with no gap; BUSY stays high; two DONE pulses.
- Truncation: second LOAD in pair cycle 2 -> only 2 writes at the old X, then 4 writes at the new X; one DONE.
- Async reset: assert nRESET=0 mid-burst between clock edges -> WE, BUSY and DONE go to 0 before the next edge. After release, no writes occur until a LOAD arrives.

Source files
------------

// File: rtl/neo_dot_lbwriter_if.sv
// Dot interface between the graphics mux and the line-buffer writer, plus the write side.
// Latency: none, this is wiring only.
// Backpressure: none. The mux streams pairs unconditionally once LOAD has been seen.
interface neo_dot_lbwriter_if;
    // mux -> writer: burst start strobe, attributes and per-cycle pixel pair
    logic        LOAD;
    logic [7:0]  PAL;
    logic [8:0]  XPOS;
    logic [3:0]  GAD;
    logic [3:0]  GBD;
    logic        DOTA;
    logic        DOTB;

    // writer -> line buffer: registered write strobes, addresses and data
    logic        WE_A;
    logic        WE_B;
    logic [8:0]  ADDR_A;
    logic [8:0]  ADDR_B;
    logic [11:0] DATA_A;
    logic [11:0] DATA_B;
    logic        BUSY;
    logic        DONE;

    // Driver side: the mux model, which also observes the write outputs
    modport master (
        output LOAD, PAL, XPOS, GAD, GBD, DOTA, DOTB,
        input  WE_A, WE_B, ADDR_A, ADDR_B, DATA_A, DATA_B, BUSY, DONE
    );

    // Writer side
    modport slave (
        input  LOAD, PAL, XPOS, GAD, GBD, DOTA, DOTB,
        output WE_A, WE_B, ADDR_A, ADDR_B, DATA_A, DATA_B, BUSY, DONE
    );
endinterface

// File: rtl/neo_dot_lbwriter.sv
// Sprite line-buffer writer: turns the mux pixel-pair stream into palette-tagged writes.
// Latency: a pair consumed in cycle n produces its write strobes, address and data in cycle n+1.
// Backpressure: none. Every RUN cycle consumes one pair, and a LOAD during RUN truncates the burst.
module neo_dot_lbwriter #(
    parameter int VIS_W = 320,   // visible line width; addresses at or above it are never written
    parameter int BURST = 4      // pixel-pair cycles per LOAD
) (
    input  logic             CLK_12M,
    input  logic             nRESET,
    neo_dot_lbwriter_if.slave dot
);

    // Counter width is guarded so a degenerate BURST of 1 still gives a legal vector
    localparam int            CW      = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] CNT_END = CW'(BURST - 1);
    // Compared at 10 bits so that a VIS_W of 512 still fits and lets every address through
    localparam logic [9:0]    VIS_LIM = 10'(VIS_W);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [7:0]    pal_q,   pal_d;
    logic [8:0]    x_q,     x_d;

    logic          we_a_q,   we_a_d;
    logic          we_b_q,   we_b_d;
    logic [8:0]    addr_a_q, addr_a_d;
    logic [8:0]    addr_b_q, addr_b_d;
    logic [11:0]   data_a_q, data_a_d;
    logic [11:0]   data_b_q, data_b_d;
    logic          done_q,   done_d;

    logic [8:0]    pair_off;
    logic [8:0]    addr_a;
    logic [8:0]    addr_b;
    logic          vis_a;
    logic          vis_b;
    logic          last_pair;

    // Addresses for the pair consumed this cycle. 9-bit sums wrap mod 512 by construction.
    // A wrapped low address is an ordinary on-screen pixel and gets written.
    always_comb begin
        pair_off  = 9'({cnt_q, 1'b0});
        addr_a    = x_q + pair_off;
        addr_b    = addr_a + 9'd1;
        vis_a     = ({1'b0, addr_a} < VIS_LIM);
        vis_b     = ({1'b0, addr_b} < VIS_LIM);
        last_pair = (cnt_q == CNT_END);
    end

    // Next-state and next-output logic. When no pair is consumed, addr/data hold their values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pal_d    = pal_q;
        x_d      = x_q;
        we_a_d   = 1'b0;
        we_b_d   = 1'b0;
        done_d   = 1'b0;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;

        case (state_q)
            IDLE: begin
                if (dot.LOAD) begin
                    pal_d   = dot.PAL;
                    x_d     = dot.XPOS;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                // The pair on the bus this cycle belongs to the current burst, even if
                // a LOAD arrives alongside it, so it is written with the old attributes.
                we_a_d   = dot.DOTA & vis_a;
                we_b_d   = dot.DOTB & vis_b;
                addr_a_d = addr_a;
                addr_b_d = addr_b;
                data_a_d = {pal_q, dot.GAD};
                data_b_d = {pal_q, dot.GBD};
                cnt_d    = cnt_q + CW'(1);

                // DONE marks only bursts that ran their full length. A truncated
                // burst never reaches its final pair, so it gets no DONE.
                if (last_pair) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end

                // A new LOAD restarts the burst. In the final pair cycle this makes
                // the next burst follow with no idle gap.
                if (dot.LOAD) begin
                    pal_d   = dot.PAL;
                    x_d     = dot.XPOS;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers. Reset clears everything at once, even mid-burst.
    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pal_q    <= '0;
            x_q      <= '0;
            we_a_q   <= 1'b0;
            we_b_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pal_q    <= pal_d;
            x_q      <= x_d;
            we_a_q   <= we_a_d;
            we_b_q   <= we_b_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            done_q   <= done_d;
        end
    end

    // Drive the outputs. BUSY comes straight from the state register, so it is
    // glitch-free and falls to 0 as soon as reset is asserted.
    always_comb begin
        dot.WE_A   = we_a_q;
        dot.WE_B   = we_b_q;
        dot.ADDR_A = addr_a_q;
        dot.ADDR_B = addr_b_q;
        dot.DATA_A = data_a_q;
        dot.DATA_B = data_b_q;
        dot.DONE   = done_q;
        dot.BUSY   = (state_q == RUN);
    end

endmodule

// File: tb/tb_neo_dot_lbwriter.sv
// Self-checking bench for neo_dot_lbwriter using a cycle-tagged scoreboard.
// Each driven cycle pushes the write outputs expected one cycle later.
// Outputs are sampled on the falling edge.
module tb_neo_dot_lbwriter;

    localparam int VIS_W = 320;
    localparam int BURST = 4;

    typedef struct packed {
        logic        we_a;
        logic        we_b;
        logic        done;
        logic [8:0]  addr_a;
        logic [8:0]  addr_b;
        logic [11:0] data_a;
        logic [11:0] data_b;
    } wr_t;

    logic CLK_12M = 1'b0;
    logic nRESET  = 1'b0;

    neo_dot_lbwriter_if bus ();

    neo_dot_lbwriter #(.VIS_W(VIS_W), .BURST(BURST)) dut (
        .CLK_12M (CLK_12M),
        .nRESET  (nRESET),
        .dot     (bus)
    );

    always #5 CLK_12M = ~CLK_12M;

    int   n_chk    = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   wr_cnt   = 0;
    wr_t  sb_q[$];

    // Bench-side view of the burst: index of the pair due this cycle (-1 when idle),
    // the latched attributes, and the address/data the line-buffer port should hold.
    int         pidx = -1;
    int         bx   = 0;
    logic [7:0] bpal = 8'h00;
    wr_t        hold = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic wr_t sample();
        wr_t s;
        s.we_a   = bus.WE_A;
        s.we_b   = bus.WE_B;
        s.done   = bus.DONE;
        s.addr_a = bus.ADDR_A;
        s.addr_b = bus.ADDR_B;
        s.data_a = bus.DATA_A;
        s.data_b = bus.DATA_B;
        return s;
    endfunction

    // Predict the outputs for the cycle after this one, from the stimulus alone.
    task automatic predict(input logic ld, input logic [7:0] pal, input logic [8:0] xp,
                           input logic [3:0] ga, input logic [3:0] gb,
                           input logic da, input logic db);
        wr_t ne;
        int  aa, ab;
        ne = hold;
        if (!nRESET) begin
            pidx = -1;
            hold = '0;
            ne   = '0;
        end else begin
            if (pidx >= 0) begin
                aa        = (bx + 2 * pidx) % 512;
                ab        = (aa + 1) % 512;
                ne.addr_a = 9'(aa);
                ne.addr_b = 9'(ab);
                ne.data_a = {bpal, ga};
                ne.data_b = {bpal, gb};
                ne.we_a   = da && (aa < VIS_W);
                ne.we_b   = db && (ab < VIS_W);
                ne.done   = (pidx == BURST - 1);
                hold      = ne;
                hold.we_a = 1'b0;
                hold.we_b = 1'b0;
                hold.done = 1'b0;
            end
            if (ld) begin
                pidx = 0;
                bx   = int'(xp);
                bpal = pal;
            end else if (pidx >= 0) begin
                pidx++;
                if (pidx == BURST) pidx = -1;
            end
        end
        sb_q.push_back(ne);
    endtask

    // One clock cycle. Entered just after a rising edge: drive the inputs, check this
    // cycle's outputs on the falling edge, push the prediction for the next cycle.
    task automatic step(input string tag, input logic ld, input logic [7:0] pal,
                        input logic [8:0] xp, input logic [3:0] ga, input logic [3:0] gb,
                        input logic da, input logic db);
        wr_t got, exp;
        logic busy_exp;
        bus.LOAD = ld;
        bus.PAL  = pal;
        bus.XPOS = xp;
        bus.GAD  = ga;
        bus.GBD  = gb;
        bus.DOTA = da;
        bus.DOTB = db;
        busy_exp = nRESET && (pidx >= 0);
        @(negedge CLK_12M);
        got = sample();
        if (sb_q.size() == 0) begin
            chk($sformatf("%s_sb_empty_c%0d", tag, cyc), 64'd0, 64'd1);
        end else begin
            exp = sb_q.pop_front();
            chk($sformatf("%s_wr_c%0d", tag, cyc), 64'(got), 64'(exp));
        end
        chk($sformatf("%s_busy_c%0d", tag, cyc), 64'(bus.BUSY), 64'(busy_exp));
        if (got.done) done_cnt++;
        wr_cnt += int'(got.we_a) + int'(got.we_b);
        predict(ld, pal, xp, ga, gb, da, db);
        @(posedge CLK_12M);
        #1;
        cyc++;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, 8'($urandom), 9'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom));
    endtask

    // Opaque pairs with recognisable colour indices
    task automatic pairs(input string tag, input int n);
        for (int k = 0; k < n; k++)
            step(tag, 1'b0, 8'h00, 9'd0, 4'(k + 1), 4'(k + 5), 1'b1, 1'b1);
    endtask

    initial begin
        bus.LOAD = 1'b0; bus.PAL  = '0; bus.XPOS = '0;
        bus.GAD  = '0;   bus.GBD  = '0; bus.DOTA = 1'b0; bus.DOTB = 1'b0;
        sb_q.push_back('0);           // outputs in the first cycle are reset values
        @(posedge CLK_12M);
        #1;
        idle("reset", 2);
        nRESET = 1'b1;
        idle("post_reset", 2);

        // Basic burst: writes at 8..15, data 0x121..0x124 / 0x125..0x128, one DONE
        done_cnt = 0; wr_cnt = 0;
        step("basic_ld", 1'b1, 8'h12, 9'd8, 4'd0, 4'd0, 1'b0, 1'b0);
        pairs("basic", 4);
        idle("basic_tail", 2);
        chk("basic_done_cnt", 64'(done_cnt), 64'd1);
        chk("basic_wr_cnt",   64'(wr_cnt),   64'd8);

        // Transparency: B is transparent on the 1st and 3rd pairs
        wr_cnt = 0;
        step("transp_ld", 1'b1, 8'h34, 9'd40, 4'd0, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            step("transp", 1'b0, 8'h00, 9'd0, 4'(k + 1), 4'(k + 9), 1'b1, 1'(k % 2));
        idle("transp_tail", 1);
        chk("transp_wr_cnt", 64'(wr_cnt), 64'd6);

        // Right-edge clip: only 316..319 are written
        wr_cnt = 0;
        step("clip_ld", 1'b1, 8'h56, 9'd316, 4'd0, 4'd0, 1'b0, 1'b0);
        pairs("clip", 4);
        idle("clip_tail", 1);
        chk("clip_wr_cnt", 64'(wr_cnt), 64'd4);

        // Wrap: 510/511 suppressed, 0..5 written
        wr_cnt = 0;
        step("wrap_ld", 1'b1, 8'h78, 9'd510, 4'd0, 4'd0, 1'b0, 1'b0);
        pairs("wrap", 4);
        idle("wrap_tail", 1);
        chk("wrap_wr_cnt", 64'(wr_cnt), 64'd6);

        // Back-to-back: LOAD in the final pair cycle, no gap, BUSY held, two DONEs
        done_cnt = 0; wr_cnt = 0;
        step("b2b_ld1", 1'b1, 8'h01, 9'd20, 4'd0, 4'd0, 1'b0, 1'b0);
        pairs("b2b_p", 3);
        step("b2b_ld2", 1'b1, 8'h02, 9'd100, 4'd4, 4'd8, 1'b1, 1'b1);
        pairs("b2b_q", 4);
        idle("b2b_tail", 2);
        chk("b2b_done_cnt", 64'(done_cnt), 64'd2);
        chk("b2b_wr_cnt",   64'(wr_cnt),   64'd16);

        // Truncation: LOAD in pair cycle 2, so 2 pairs at x=8 then 4 at x=200 and one DONE
        done_cnt = 0; wr_cnt = 0;
        step("trunc_ld1", 1'b1, 8'hAA, 9'd8, 4'd0, 4'd0, 1'b0, 1'b0);
        pairs("trunc_p", 1);
        step("trunc_ld2", 1'b1, 8'hBB, 9'd200, 4'd2, 4'd6, 1'b1, 1'b1);
        pairs("trunc_q", 4);
        idle("trunc_tail", 2);
        chk("trunc_done_cnt", 64'(done_cnt), 64'd1);
        chk("trunc_wr_cnt",   64'(wr_cnt),   64'd12);

        // Async reset mid-burst, between edges
        step("arst_ld", 1'b1, 8'hCC, 9'd30, 4'd0, 4'd0, 1'b0, 1'b0);
        pairs("arst_p", 2);
        bus.LOAD = 1'b0; bus.GAD = 4'd3; bus.GBD = 4'd7; bus.DOTA = 1'b1; bus.DOTB = 1'b1;
        #2;
        nRESET = 1'b0;
        #1;
        chk("arst_we_a", 64'(bus.WE_A), 64'd0);
        chk("arst_we_b", 64'(bus.WE_B), 64'd0);
        chk("arst_busy", 64'(bus.BUSY), 64'd0);
        chk("arst_done", 64'(bus.DONE), 64'd0);
        chk("arst_addr", 64'(bus.ADDR_A), 64'd0);
        sb_q.delete();
        pidx = -1;
        hold = '0;
        sb_q.push_back('0);
        @(posedge CLK_12M);
        #1;
        cyc++;
        idle("arst_hold", 2);
        nRESET = 1'b1;
        wr_cnt = 0;
        for (int i = 0; i < 6; i++)
            step("arst_idle", 1'b0, 8'h00, 9'd0, 4'($urandom), 4'($urandom), 1'b1, 1'b1);
        chk("arst_no_wr", 64'(wr_cnt), 64'd0);

        // Fresh burst after reset, checked by the scoreboard as usual
        step("arst_ld2", 1'b1, 8'hDD, 9'd64, 4'd0, 4'd0, 1'b0, 1'b0);
        pairs("arst_q", 4);
        idle("end", 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
